// File: rtl/imem_load_arb_if.sv
// Loader, fetch and IMEM bus bundle for imem_load_arb.
// slave is the arbiter side, master is the loader/fetch/memory side.
interface imem_load_arb_if #(
    parameter int AW = 10
) ();
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_start;
    logic [31:0]   fetch_addr;
    logic [31:0]   fetch_instr;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic [31:0]   imem_rdata;
    logic          core_hold;
    logic          err;
    logic [AW:0]   words_loaded;

    modport slave (
        input  ld_valid, ld_data, ld_last, ld_start,
        input  fetch_addr, imem_rdata,
        output ld_ready, fetch_instr, imem_we,
        output imem_addr, imem_wdata,
        output core_hold, err, words_loaded
    );

    modport master (
        output ld_valid, ld_data, ld_last, ld_start,
        output fetch_addr, imem_rdata,
        input  ld_ready, fetch_instr, imem_we,
        input  imem_addr, imem_wdata,
        input  core_hold, err, words_loaded
    );
endinterface

// File: rtl/imem_load_arb.sv
// IMEM boot loader / fetch arbiter: streams an image into IMEM, then hands it to fetch.
// Optional: define IMEM_LOAD_CHECKSUM_EN to treat the last beat as a sum trailer.
module imem_load_arb #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic            clk,
    input  logic            rst,
    imem_load_arb_if.slave  bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_ERROR
    } state_e;

    state_e      state_q;
    logic [AW:0] cnt_q;
    logic [AW:0] cnt_d;
    logic        err_q;
    logic        core_hold_q;
    logic        ld_ready_q;
    logic        beat;
    logic        at_top;
    logic        write;

    // Reset gates the write strobe so nothing lands in IMEM while rst is high.
    assign beat   = bus.ld_valid & ld_ready_q & ~rst;
    assign at_top = (cnt_q == (AW+1)'(DEPTH - 1));
    assign cnt_d  = cnt_q + (AW+1)'(1);

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] sum_q;
    logic [31:0] sum_d;

    assign sum_d = sum_q + bus.ld_data;
    assign write = beat & ~bus.ld_last;
`else
    assign write = beat;
`endif

    assign bus.ld_ready     = ld_ready_q;
    assign bus.core_hold    = core_hold_q;
    assign bus.err          = err_q;
    assign bus.words_loaded = cnt_q;
    assign bus.imem_we      = write;
    assign bus.imem_wdata   = write ? bus.ld_data : 32'h0;

    assign bus.imem_addr = (state_q == S_RUN) ? bus.fetch_addr
        : {{(30 - AW){1'b0}}, cnt_q[AW-1:0], 2'b00};

    assign bus.fetch_instr = (state_q == S_RUN) ? bus.imem_rdata : NOP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            core_hold_q <= 1'b1;
            ld_ready_q  <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (beat) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        if (bus.ld_last) begin
                            ld_ready_q <= 1'b0;
                            if (bus.ld_data == sum_q) begin
                                state_q     <= S_RUN;
                                core_hold_q <= 1'b0;
                            end else begin
                                state_q <= S_ERROR;
                                err_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                            sum_q <= sum_d;
                            if (at_top) begin
                                state_q    <= S_ERROR;
                                err_q      <= 1'b1;
                                ld_ready_q <= 1'b0;
                            end
                        end
`else
                        cnt_q <= cnt_d;
                        if (bus.ld_last) begin
                            state_q     <= S_RUN;
                            core_hold_q <= 1'b0;
                            ld_ready_q  <= 1'b0;
                        end else if (at_top) begin
                            state_q    <= S_ERROR;
                            err_q      <= 1'b1;
                            ld_ready_q <= 1'b0;
                        end
`endif
                    end
                end
                S_RUN, S_ERROR: begin
                    if (bus.ld_start) begin
                        state_q     <= S_LOAD;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        core_hold_q <= 1'b1;
                        ld_ready_q  <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        sum_q       <= '0;
`endif
                    end
                end
                default: begin
                    state_q     <= S_LOAD;
                    cnt_q       <= '0;
                    err_q       <= 1'b0;
                    core_hold_q <= 1'b1;
                    ld_ready_q  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/imem_load_arb.md
IMEM_LOAD_ARB -- requirements
Module: imem_load_arb

Interface
- REQ-001: Parameter DEPTH, default 1024; IMEM capacity in 32-bit words, power of two, at least 4.
- REQ-002: Parameter AW, default 10; word-index width, equal to log2(DEPTH).
- REQ-003: clk  in  1  single clock; all state updates on its rising edge.
- REQ-004: rst  in  1  asynchronous, active-high reset.
- REQ-005: ld_valid  in  1  the loader presents a program word.
- REQ-006: ld_ready  out  1  the block accepts the word; a beat transfers when ld_valid and ld_ready are both high.
- REQ-007: ld_data  in  32  program word.
- REQ-008: ld_last  in  1  marks the final beat of an image.
- REQ-009: ld_start  in  1  single-cycle request to reload a new image.
- REQ-010: fetch_addr  in  32  byte PC from the fetch stage.
- REQ-011: fetch_instr  out  32  instruction returned to the fetch stage.
- REQ-012: imem_we  out  1  IMEM write enable.
- REQ-013: imem_addr  out  32  IMEM byte address.
- REQ-014: imem_wdata  out  32  IMEM write data.
- REQ-015: imem_rdata  in  32  IMEM combinational read data.
- REQ-016: core_hold  out  1  holds the fetch PC and pipeline registers in reset while high.
- REQ-017: err  out  1  sticky load-failure flag.
- REQ-018: words_loaded  out  AW+1  count of words written by the current or last load.

Function
- REQ-019: The FSM SHALL have three states: LOAD, RUN and ERROR, encoded as registered state.
- REQ-020: In LOAD:
  - ld_ready=1 and core_hold=1.
  - On each accepted beat, in the same cycle: imem_we=1, imem_addr={cnt,2'b00} zero-extended, imem_wdata=ld_data.
  - cnt increments by 1 on each accepted beat.
- REQ-021: In LOAD, an accepted beat with ld_last=1 SHALL transition to RUN on the next edge.
- REQ-022: In LOAD, an accepted beat at cnt==DEPTH-1 with ld_last=0 SHALL be written, then transition to ERROR (overflow).
- REQ-023: In RUN:
  - ld_ready=0, imem_we=0, core_hold=0.
  - imem_addr=fetch_addr and fetch_instr=imem_rdata, both combinational with zero added latency.
- REQ-024: In LOAD and ERROR, fetch_instr SHALL be 32'h0000_0013 (NOP).
- REQ-025: When imem_we=0, imem_wdata SHALL be 0.
- REQ-026: ld_start high in RUN or ERROR SHALL, on the next edge:
  - enter LOAD;
  - clear cnt and err;
  - set core_hold=1.
- REQ-027: ld_start SHALL be ignored while in LOAD; any beat in that cycle is processed normally.
- REQ-028: words_loaded SHALL equal cnt, i.e. the number of words written, and SHALL hold its value in RUN and ERROR.
- REQ-029: In ERROR: core_hold=1, ld_ready=0, err=1; the block stays in ERROR until ld_start.
- REQ-030: ld_valid with ld_ready=0 SHALL have no effect.

Reset
- REQ-031: While rst is high, and immediately after it is released, the block SHALL be in LOAD with the following values:
  - cnt=0, err=0, core_hold=1, ld_ready=1;
  - imem_we=0, imem_wdata=0, imem_addr=0;
  - fetch_instr=32'h0000_0013.
- REQ-032: rst asserted mid-load SHALL abandon the image; words already written remain in IMEM, and loading restarts at word 0.

Configuration
- REQ-033: Macro IMEM_LOAD_CHECKSUM_EN.
  - Defined: the ld_last beat is a checksum trailer and is not written to IMEM. A 32-bit running sum (mod 2^32) of the written words is kept and is cleared on reset and on ld_start. If trailer == sum, go to RUN; otherwise go to ERROR.
  - Undefined: the ld_last beat is an ordinary data word, and there is no checksum logic.

Verification
- REQ-034: Reset, then 3 beats 0x00500093, 0x00100113, 0x002081B3 (the third with last), macro off -> IMEM words 0..2 written at addresses 0x0, 0x4, 0x8; RUN; words_loaded=3; core_hold falls.
- REQ-035: In RUN, fetch_addr=0x4 -> imem_addr=0x4 and fetch_instr=imem_rdata in the same cycle; imem_we=0.
- REQ-036: DEPTH=4, 4 beats with no last -> 4 writes, then ERROR; err=1; ld_ready=0; fetch_instr=0x00000013.
- REQ-037: Macro on: words 1, 2, then trailer 3 -> RUN with words_loaded=2. Repeat with trailer 4 -> ERROR.
- REQ-038: In RUN, pulse ld_start, then load 1 word with last -> core_hold=1 within 1 cycle, cnt restarts at 0, write to address 0x0, back to RUN.
- REQ-039: Assert rst after 2 of 5 beats -> LOAD with cnt=0; the next accepted beat is written to address 0x0.
